process_fifo_sync: RTL and testbench

Single-clock synchronous FIFO buffering an 8-bit processed-pixel stream between a producer and the output layer's write-back engine. The consumer polls data_count and pulls bytes with rd_en. Standard (non-first-word-fall-through) read mode: data appears on dout one cycle after an accepted read.

---
 rtl/process_fifo_sync.sv | 91 +++++++++
 tb/tb_process_fifo_sync.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/process_fifo_sync.sv
// process_fifo_sync
// Single-clock FIFO that buffers the 8-bit processed-pixel stream ahead of the
// output layer's write-back engine. Reads are standard (not first-word
// fall-through): a byte appears on dout the cycle after an accepted read.
//
// Ports:
//   clk        rising-edge clock for all state
//   srst       asynchronous, active-high reset
//   din        write data
//   wr_en      write request (dropped while full)
//   rd_en      read request (ignored while empty)
//   dout       registered read data, holds between reads
//   full       registered, high when data_count == DEPTH
//   empty      registered, high when data_count == 0
//   data_count number of stored entries (0..DEPTH)
module process_fifo_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 512,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] data_count
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0]  wptr_r;
    logic [ADDR_WIDTH-1:0]  rptr_r;
    logic                   wr_acc_s;
    logic                   rd_acc_s;
    logic [COUNT_WIDTH-1:0] count_next_s;

    // Acceptance uses the registered flags, so a write into a full FIFO or a
    // read from an empty one is simply not accepted.
    assign wr_acc_s = wr_en & ~full;
    assign rd_acc_s = rd_en & ~empty;

    // Next occupancy: +1 write only, -1 read only, unchanged for both/neither.
    always_comb begin
        count_next_s = data_count;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = data_count + COUNT_WIDTH'(1);
            2'b01:   count_next_s = data_count - COUNT_WIDTH'(1);
            2'b11:   count_next_s = data_count;
            default: count_next_s = data_count;
        endcase
    end

    // Storage array; kept free of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Pointers, read register, count and flags. Flags come from the next count
    // so they always agree with data_count in the same cycle.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wptr_r     <= {ADDR_WIDTH{1'b0}};
            rptr_r     <= {ADDR_WIDTH{1'b0}};
            dout       <= {DATA_WIDTH{1'b0}};
            data_count <= {COUNT_WIDTH{1'b0}};
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + ADDR_WIDTH'(1);
            end
            if (rd_acc_s) begin
                // Read of the oldest stored word; a same-cycle write lands at
                // wptr_r, never at rptr_r when empty (the read is refused then),
                // so there is no write-to-read bypass.
                dout   <= mem_r[rptr_r];
                rptr_r <= rptr_r + ADDR_WIDTH'(1);
            end
            data_count <= count_next_s;
            full       <= (count_next_s == COUNT_WIDTH'(DEPTH));
            empty      <= (count_next_s == {COUNT_WIDTH{1'b0}});
        end
    end

endmodule

// File: tb/tb_process_fifo_sync.sv
// Testbench for process_fifo_sync. The stimulus side keeps a plain queue as
// the reference FIFO; each accepted read pushes its expected byte into a
// scoreboard queue, and an independent monitor pops and compares dout, and
// checks occupancy and flags after every clock edge.
module tb_process_fifo_sync;

    localparam int DEPTH = 512;

    logic       clk;
    logic       srst;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [9:0] data_count;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout;
    bit         rd_pending;
    int         vectors;
    int         miscompares;

    process_fifo_sync #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH),
        .COUNT_WIDTH(10)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .data_count(data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: after each edge, retire any expected read and check outputs.
    always @(posedge clk) begin
        #1;
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underrun", 0, 1);
            end else begin
                exp_dout = exp_q.pop_front();
            end
            rd_pending = 1'b0;
        end
        chk("dout", int'(dout), int'(exp_dout));
        chk("data_count", int'(data_count), model_q.size());
        chk("full", int'(full), int'(model_q.size() == DEPTH));
        chk("empty", int'(empty), int'(model_q.size() == 0));
    end

    // One clock of stimulus; the reference FIFO decides acceptance from its
    // own occupancy before the edge.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        din   = d;
        wr_en = w;
        rd_en = r;
        rd_ok = r && (model_q.size() != 0);
        wr_ok = w && (model_q.size() != DEPTH);
        if (rd_ok) begin
            exp_q.push_back(model_q.pop_front());
            rd_pending = 1'b1;
        end
        if (wr_ok) begin
            model_q.push_back(d);
        end
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        exp_dout   = 8'd0;
        rd_pending = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        din         = 8'd0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        exp_dout    = 8'd0;
        rd_pending  = 1'b0;
        srst        = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;

        // Basic ordering
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'd0);

        // Fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'd0);

        // Underflow, then pointer sanity
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'd0);
        cycle(1'b1, 1'b0, 8'h5C);
        cycle(1'b0, 1'b1, 8'd0);

        // Simultaneous access when empty, full and partly filled
        cycle(1'b1, 1'b1, 8'd7);
        cycle(1'b0, 1'b1, 8'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i * 3 + 1));
        cycle(1'b1, 1'b1, 8'h99);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(i + 100));
        cycle(1'b1, 1'b1, 8'h42);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'd0);

        // Asynchronous reset mid-cycle with 20 entries held and dout non-zero
        for (int i = 1; i <= 21; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b0, 1'b1, 8'd0);
        @(negedge clk);
        #2;
        srst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_count", int'(data_count), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_full", int'(full), 0);
        chk("async_rst_dout", int'(dout), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;

        // Random soak
        for (int i = 0; i < 20000; i++) begin
            bit w;
            bit r;
            w = ($urandom_range(0, 1) == 1) && (model_q.size() < 500);
            r = ($urandom_range(0, 2) != 0);
            if (i % 4000 < 1500) r = ($urandom_range(0, 3) == 0);
            cycle(w, r, 8'($urandom_range(0, 255)));
        end
        while (model_q.size() != 0) cycle(1'b0, 1'b1, 8'd0);
        repeat (3) @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
